// File: rtl/mem_arb32.sv
// Two-requester arbiter (fetch vs. data) for one shared single-port RAM; grants are same-cycle combinational.
// Read data returns exactly 1 cycle after grant; no backpressure, and a loser simply holds its request (fetch stalls the PC).
module mem_arb32 #(
  parameter int WIDTH      = 32,
  parameter int MAX_DBURST = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [WIDTH-1:0] ram_ad,
  output logic [WIDTH-1:0] ram_d,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_q,
  output logic             pc_stall
);

  localparam int            CW   = (MAX_DBURST < 1) ? 1 : $clog2(MAX_DBURST + 1);
  localparam logic [CW-1:0] DMAX = CW'(MAX_DBURST);

  typedef enum logic [1:0] {IDLE, IF_RD, D_RD} rd_state_e;

  rd_state_e     state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          d_win;
  logic          if_win;

  // Data wins unless it has already taken MAX_DBURST grants in a row past a waiting fetch.
  always_comb begin
    d_win  = d_req && (!if_req || (dcnt_q < DMAX));
    if_win = if_req && !d_win;
  end

  assign if_gnt   = if_win && !reset;
  assign d_gnt    = d_win && !reset;
  assign pc_stall = if_req && !if_gnt && !reset;

  assign ram_we = d_gnt && d_we;
  assign ram_d  = ram_we ? d_wdata : '0;
  assign ram_ad = if_gnt ? if_addr : (d_gnt ? d_addr : '0);

  always_comb begin
    dcnt_d = dcnt_q;
    if (!if_req || if_gnt) begin
      dcnt_d = '0;
    end else if (d_gnt && (dcnt_q < DMAX)) begin
      dcnt_d = dcnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = IF_RD;
    end else if (d_gnt && !d_we) begin
      state_d = D_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // A response due in a reset cycle is dropped, not replayed; the requester reissues.
  assign if_rvalid = (state_q == IF_RD) && !reset;
  assign d_rvalid  = (state_q == D_RD) && !reset;
  assign if_rdata  = if_rvalid ? ram_q : '0;
  assign d_rdata   = d_rvalid ? ram_q : '0;

endmodule

// File: doc/mem_arb32.md
MEM_ARB32 -- requirements
Module: mem_arb32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data and address width (`FULLW).
REQ-002 SHALL have parameter MAX_DBURST, default 2, the maximum consecutive data grants while a fetch waits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request.
REQ-006 SHALL have port if_addr  input  WIDTH  fetch address.
REQ-007 SHALL have port if_gnt  output  1  fetch accepted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch data valid.
REQ-009 SHALL have port if_rdata  output  WIDTH  fetch data.
REQ-010 SHALL have port d_req  input  1  data load/store request.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  WIDTH  data address.
REQ-013 SHALL have port d_wdata  input  WIDTH  store data.
REQ-014 SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-015 SHALL have port d_rvalid  output  1  load data valid.
REQ-016 SHALL have port d_rdata  output  WIDTH  load data.
REQ-017 SHALL have port ram_ad  output  WIDTH  shared RAM address.
REQ-018 SHALL have port ram_d  output  WIDTH  shared RAM write data.
REQ-019 SHALL have port ram_we  output  1  shared RAM write enable.
REQ-020 SHALL have port ram_q  input  WIDTH  shared RAM read data, valid one cycle after address.
REQ-021 SHALL have port pc_stall  output  1  fetch pending but not granted; drives PC enable low.

Function
REQ-022 SHALL grant at most one requester per cycle; if_gnt and d_gnt never high together.
REQ-023 SHALL grant data when d_req=1 and (if_req=0 or dcnt<MAX_DBURST); otherwise grant fetch when if_req=1; otherwise grant neither.
REQ-024 SHALL derive grants combinationally from the same-cycle requests and registered state; a request is accepted in the cycle its grant is high.
REQ-025 SHALL keep a starvation counter dcnt: +1 on a data grant while if_req=1, saturating at MAX_DBURST; cleared on any fetch grant or whenever if_req=0.
REQ-026 SHALL drive ram_ad=if_addr on fetch grant, ram_ad=d_addr on data grant, and ram_ad=0 with no grant.
REQ-027 SHALL drive ram_we=d_gnt&d_we and ram_d=d_wdata on a store grant, ram_d=0 otherwise.
REQ-028 SHALL hold a registered read-owner FSM with states IDLE, IF_RD and D_RD; next state is IF_RD on fetch grant, D_RD on load grant, and IDLE on store grant or no grant.
REQ-029 SHALL assert if_rvalid in state IF_RD and d_rvalid in state D_RD, with the data equal to ram_q; this gives a fixed read latency of 1 cycle after grant.
REQ-030 SHALL drive if_rdata/d_rdata to 0 whenever the matching rvalid is 0.
REQ-031 SHALL never produce an rvalid for a store.
REQ-032 SHALL sustain back-to-back grants every cycle; a response and a new grant can coincide.
REQ-033 SHALL assert pc_stall=if_req&~if_gnt.
REQ-034 SHALL perform no address comparison or forwarding; read-after-write ordering follows grant order at the RAM.

Reset
REQ-035 SHALL, in any cycle with reset=1, force if_gnt=d_gnt=0, ram_we=0, ram_ad=0 and pc_stall=0.
REQ-036 SHALL, in any cycle with reset=1, load FSM=IDLE and dcnt=0 at the clock edge.
REQ-037 SHALL, after reset, output if_rvalid=d_rvalid=0 and both rdata buses 0 in the first cycle after reset deasserts.
REQ-038 SHALL, when reset asserts in the cycle a read response is due, suppress that response and not replay it; the requester reissues.

Verification
REQ-039 SHALL cover fetch only: if_req=1, if_addr=0x10, ram_q=0xE3A01005 next cycle -> if_gnt=1, then if_rvalid=1 with if_rdata=0xE3A01005; pc_stall=0 throughout.
REQ-040 SHALL cover a contended load: if_req=d_req=1, d_we=0, d_addr=0x40 -> d_gnt=1, ram_ad=0x40, pc_stall=1; next cycle d_rvalid=1 and if_rvalid=0.
REQ-041 SHALL cover starvation bound: if_req and d_req held high for 6 cycles with MAX_DBURST=2 -> grant pattern D,D,IF,D,D,IF.
REQ-042 SHALL cover a store: d_req=1, d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> ram_we=1, ram_d=0xDEADBEEF; no rvalid next cycle.
REQ-043 SHALL cover reset mid-read: fetch granted at cycle N, reset=1 at N+1 -> if_rvalid=0 at N+1 and N+2, FSM IDLE, no grant during reset.
REQ-044 SHALL check on every cycle that if_gnt&d_gnt=0 and that ram_we=1 only when d_gnt=1.
